// File: rtl/basic_axi4_lite_master_if.sv
// AXI4-Lite bus bundle between basic_axi4_lite_master and a register slave.
// Signal names keep the master-side o_M_*/i_S_* naming so both ends read the same.
interface basic_axi4_lite_master_if #(
  parameter int p_ADDRESS_WIDTH = 2,
  parameter int p_DATA_WIDTH    = 8
);
  logic [p_ADDRESS_WIDTH-1:0] o_M_AWADDR;
  logic                       o_M_AWVALID;
  logic                       i_S_AWREADY;
  logic [p_DATA_WIDTH-1:0]    o_M_WDATA;
  logic                       o_M_WVALID;
  logic                       i_S_WREADY;
  logic [1:0]                 i_S_BRESP;
  logic                       i_S_BVALID;
  logic                       o_M_BREADY;
  logic [p_ADDRESS_WIDTH-1:0] o_M_ARADDR;
  logic                       o_M_ARVALID;
  logic                       i_S_ARREADY;
  logic [p_DATA_WIDTH-1:0]    i_S_RDATA;
  logic [1:0]                 i_S_RRESP;
  logic                       i_S_RVALID;
  logic                       o_M_RREADY;

  modport master (
    output o_M_AWADDR, o_M_AWVALID, o_M_WDATA, o_M_WVALID, o_M_BREADY,
           o_M_ARADDR, o_M_ARVALID, o_M_RREADY,
    input  i_S_AWREADY, i_S_WREADY, i_S_BRESP, i_S_BVALID,
           i_S_ARREADY, i_S_RDATA, i_S_RRESP, i_S_RVALID
  );

  modport slave (
    input  o_M_AWADDR, o_M_AWVALID, o_M_WDATA, o_M_WVALID, o_M_BREADY,
           o_M_ARADDR, o_M_ARVALID, o_M_RREADY,
    output i_S_AWREADY, i_S_WREADY, i_S_BRESP, i_S_BVALID,
           i_S_ARREADY, i_S_RDATA, i_S_RRESP, i_S_RVALID
  );
endinterface

// File: rtl/basic_axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one user command into one AW/W/B or AR/R
// transaction and returns exactly one response per command.
module basic_axi4_lite_master #(
  parameter int p_ADDRESS_WIDTH = 2,
  parameter int p_DATA_WIDTH    = 8
) (
  input  logic                       i_ACLK,
  input  logic                       i_ARESET,
  input  logic                       i_CMD_VALID,
  output logic                       o_CMD_READY,
  input  logic                       i_CMD_WRITE,
  input  logic [p_ADDRESS_WIDTH-1:0] i_CMD_ADDR,
  input  logic [p_DATA_WIDTH-1:0]    i_CMD_WDATA,
  output logic                       o_RSP_VALID,
  input  logic                       i_RSP_READY,
  output logic                       o_RSP_WRITE,
  output logic [p_DATA_WIDTH-1:0]    o_RSP_RDATA,
  output logic [1:0]                 o_RSP_RESP,
  basic_axi4_lite_master_if.master   m_axi
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP
  } state_t;

  state_t                     state_q;
  logic [p_ADDRESS_WIDTH-1:0] awaddr_q, araddr_q;
  logic [p_DATA_WIDTH-1:0]    wdata_q, rsp_rdata_q;
  logic                       awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                       rsp_valid_q, rsp_write_q;
  logic [1:0]                 rsp_resp_q;
  logic                       aw_done, w_done;

  // A channel is finished if it already handshook earlier or handshakes on this edge.
  assign aw_done = ~awvalid_q | m_axi.i_S_AWREADY;
  assign w_done  = ~wvalid_q  | m_axi.i_S_WREADY;

  assign o_CMD_READY = (state_q == IDLE) & ~i_ARESET;

  always_ff @(posedge i_ACLK) begin
    if (i_ARESET) begin
      state_q     <= IDLE;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_CMD_VALID) begin
            if (i_CMD_WRITE) begin
              awaddr_q  <= i_CMD_ADDR;
              wdata_q   <= i_CMD_WDATA;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_ADDR_DATA;
            end else begin
              araddr_q  <= i_CMD_ADDR;
              arvalid_q <= 1'b1;
              state_q   <= RD_ADDR;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (awvalid_q && m_axi.i_S_AWREADY) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi.i_S_WREADY)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi.i_S_BVALID) begin
            rsp_resp_q  <= m_axi.i_S_BRESP;
            rsp_rdata_q <= '0;
            rsp_write_q <= 1'b1;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end
        RD_ADDR: begin
          if (m_axi.i_S_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi.i_S_RVALID) begin
            rsp_rdata_q <= m_axi.i_S_RDATA;
            rsp_resp_q  <= m_axi.i_S_RRESP;
            rsp_write_q <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end
        RSP: begin
          if (i_RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axi.o_M_AWADDR  = awaddr_q;
  assign m_axi.o_M_AWVALID = awvalid_q;
  assign m_axi.o_M_WDATA   = wdata_q;
  assign m_axi.o_M_WVALID  = wvalid_q;
  assign m_axi.o_M_BREADY  = bready_q;
  assign m_axi.o_M_ARADDR  = araddr_q;
  assign m_axi.o_M_ARVALID = arvalid_q;
  assign m_axi.o_M_RREADY  = rready_q;

  assign o_RSP_VALID = rsp_valid_q;
  assign o_RSP_WRITE = rsp_write_q;
  assign o_RSP_RDATA = rsp_rdata_q;
  assign o_RSP_RESP  = rsp_resp_q;

endmodule

// File: tb/tb_basic_axi4_lite_master.sv
// Bench for basic_axi4_lite_master: scripted slave timing plus a response scoreboard.
module tb_basic_axi4_lite_master;

  typedef struct packed {
    logic       wr;
    logic [7:0] rdata;
    logic [1:0] resp;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_write, rsp_ready;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       cmd_ready, rsp_valid, rsp_write;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_resp;

  int   total = 0;
  int   bad   = 0;
  int   rsp_cnt = 0;
  int   cnt_snap;
  rsp_t exp_q[$];

  basic_axi4_lite_master_if #(.p_ADDRESS_WIDTH(2), .p_DATA_WIDTH(8)) bus ();

  basic_axi4_lite_master #(.p_ADDRESS_WIDTH(2), .p_DATA_WIDTH(8)) dut (
    .i_ACLK      (clk),
    .i_ARESET    (rst),
    .i_CMD_VALID (cmd_valid),
    .o_CMD_READY (cmd_ready),
    .i_CMD_WRITE (cmd_write),
    .i_CMD_ADDR  (cmd_addr),
    .i_CMD_WDATA (cmd_wdata),
    .o_RSP_VALID (rsp_valid),
    .i_RSP_READY (rsp_ready),
    .o_RSP_WRITE (rsp_write),
    .o_RSP_RDATA (rsp_rdata),
    .o_RSP_RESP  (rsp_resp),
    .m_axi       (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic wr, input logic [1:0] addr, input logic [7:0] data);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
  endtask

  // Response monitor: pops the scoreboard on every response handshake.
  always @(posedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_write", {31'd0, rsp_write}, {31'd0, e.wr});
        check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
        check("rsp_resp",  {30'd0, rsp_resp},  {30'd0, e.resp});
      end
    end
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    send(1'b1, 2'd3, 8'hFF);
    bus.i_S_AWREADY = 1'b0; bus.i_S_WREADY = 1'b0; bus.i_S_BVALID = 1'b0;
    bus.i_S_BRESP = 2'b00; bus.i_S_ARREADY = 1'b0; bus.i_S_RVALID = 1'b0;
    bus.i_S_RDATA = 8'h00; bus.i_S_RRESP = 2'b00;

    // Test 1: reset held 3 cycles with a pending command
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("rst_valids", {27'd0, bus.o_M_AWVALID, bus.o_M_WVALID, bus.o_M_ARVALID,
                           rsp_valid, bus.o_M_BREADY | bus.o_M_RREADY}, 32'd0);
      check("rst_data", {22'd0, bus.o_M_AWADDR, bus.o_M_WDATA}, 32'd0);
    end
    rst = 1'b0;
    #1 check("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b0;

    // Test 2: write addr 0 data 9, slave always ready, BVALID next cycle
    tick();
    send(1'b1, 2'd0, 8'h09);
    exp_q.push_back('{wr: 1'b1, rdata: 8'h00, resp: 2'b00});
    bus.i_S_AWREADY = 1'b1; bus.i_S_WREADY = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("t2_awvalid", {31'd0, bus.o_M_AWVALID}, 32'd1);
    check("t2_wvalid",  {31'd0, bus.o_M_WVALID},  32'd1);
    check("t2_wdata",   {24'd0, bus.o_M_WDATA},   32'h09);
    check("t2_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    tick();
    check("t2_aw_w_dropped", {30'd0, bus.o_M_AWVALID, bus.o_M_WVALID}, 32'd0);
    check("t2_bready", {31'd0, bus.o_M_BREADY}, 32'd1);
    bus.i_S_AWREADY = 1'b0; bus.i_S_WREADY = 1'b0;
    bus.i_S_BVALID = 1'b1; bus.i_S_BRESP = 2'b00;
    tick();
    bus.i_S_BVALID = 1'b0;
    check("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("t2_bready_clr", {31'd0, bus.o_M_BREADY}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t2_rsp_done", {31'd0, rsp_valid}, 32'd0);

    // Test 3: write addr 2 data A5, WREADY 3 cycles after AWREADY
    cnt_snap = rsp_cnt;
    send(1'b1, 2'd2, 8'hA5);
    exp_q.push_back('{wr: 1'b1, rdata: 8'h00, resp: 2'b00});
    bus.i_S_AWREADY = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("t3_awaddr", {30'd0, bus.o_M_AWADDR}, 32'd2);
    check("t3_awvalid", {31'd0, bus.o_M_AWVALID}, 32'd1);
    tick();
    bus.i_S_AWREADY = 1'b0;
    check("t3_awvalid_drop", {31'd0, bus.o_M_AWVALID}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("t3_wvalid_hold", {31'd0, bus.o_M_WVALID}, 32'd1);
      check("t3_wdata_hold",  {24'd0, bus.o_M_WDATA},  32'hA5);
      check("t3_no_bready",   {31'd0, bus.o_M_BREADY}, 32'd0);
      if (i == 2) bus.i_S_WREADY = 1'b1;
      tick();
    end
    bus.i_S_WREADY = 1'b0;
    check("t3_wvalid_drop", {31'd0, bus.o_M_WVALID}, 32'd0);
    check("t3_bready", {31'd0, bus.o_M_BREADY}, 32'd1);
    bus.i_S_BVALID = 1'b1;
    tick();
    bus.i_S_BVALID = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    check("t3_one_rsp", rsp_cnt - cnt_snap, 32'd1);

    // Test 4: read addr 0, ARREADY late, RVALID after 2 cycles
    send(1'b0, 2'd0, 8'h00);
    exp_q.push_back('{wr: 1'b0, rdata: 8'h09, resp: 2'b00});
    tick();
    cmd_valid = 1'b0;
    check("t4_arvalid", {31'd0, bus.o_M_ARVALID}, 32'd1);
    check("t4_araddr", {30'd0, bus.o_M_ARADDR}, 32'd0);
    tick();
    check("t4_arvalid_hold", {31'd0, bus.o_M_ARVALID}, 32'd1);
    bus.i_S_ARREADY = 1'b1;
    tick();
    bus.i_S_ARREADY = 1'b0;
    check("t4_arvalid_drop", {31'd0, bus.o_M_ARVALID}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      check("t4_rready", {31'd0, bus.o_M_RREADY}, 32'd1);
      tick();
    end
    bus.i_S_RVALID = 1'b1; bus.i_S_RDATA = 8'h09; bus.i_S_RRESP = 2'b00;
    tick();
    bus.i_S_RVALID = 1'b0;
    check("t4_rready_clr", {31'd0, bus.o_M_RREADY}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Test 5: read with SLVERR, response stalled 5 cycles under a pending command
    send(1'b0, 2'd1, 8'h00);
    exp_q.push_back('{wr: 1'b0, rdata: 8'h3C, resp: 2'b10});
    tick();
    cmd_valid = 1'b0;
    bus.i_S_ARREADY = 1'b1;
    tick();
    bus.i_S_ARREADY = 1'b0;
    bus.i_S_RVALID = 1'b1; bus.i_S_RDATA = 8'h3C; bus.i_S_RRESP = 2'b10;
    tick();
    bus.i_S_RVALID = 1'b0; bus.i_S_RDATA = 8'h00; bus.i_S_RRESP = 2'b00;
    send(1'b1, 2'd3, 8'h77);
    for (int i = 0; i < 5; i++) begin
      check("t5_rsp_hold", {20'd0, rsp_valid, rsp_write, rsp_rdata, rsp_resp}, {20'd0, 1'b1, 1'b0, 8'h3C, 2'b10});
      check("t5_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t5_not_accepted_early", {31'd0, bus.o_M_AWVALID}, 32'd0);
    check("t5_cmd_ready_again", {31'd0, cmd_ready}, 32'd1);
    exp_q.push_back('{wr: 1'b1, rdata: 8'h00, resp: 2'b01});
    tick();
    cmd_valid = 1'b0;
    check("t5_second_cmd", {20'd0, bus.o_M_AWVALID, bus.o_M_AWADDR, bus.o_M_WDATA}, {20'd0, 1'b1, 2'd3, 8'h77});
    bus.i_S_AWREADY = 1'b1; bus.i_S_WREADY = 1'b1;
    tick();
    bus.i_S_AWREADY = 1'b0; bus.i_S_WREADY = 1'b0;
    bus.i_S_BVALID = 1'b1; bus.i_S_BRESP = 2'b01;
    tick();
    bus.i_S_BVALID = 1'b0; bus.i_S_BRESP = 2'b00;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Test 6: reset while waiting in WR_RESP
    cnt_snap = rsp_cnt;
    send(1'b1, 2'd1, 8'h55);
    tick();
    cmd_valid = 1'b0;
    bus.i_S_AWREADY = 1'b1; bus.i_S_WREADY = 1'b1;
    tick();
    bus.i_S_AWREADY = 1'b0; bus.i_S_WREADY = 1'b0;
    check("t6_in_wr_resp", {31'd0, bus.o_M_BREADY}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_bready_clr", {31'd0, bus.o_M_BREADY}, 32'd0);
    check("t6_valids_clr", {28'd0, bus.o_M_AWVALID, bus.o_M_WVALID, bus.o_M_ARVALID, rsp_valid}, 32'd0);
    check("t6_data_clr", {22'd0, bus.o_M_AWADDR, bus.o_M_WDATA}, 32'd0);
    bus.i_S_BVALID = 1'b1;
    rsp_ready = 1'b1;
    tick();
    tick();
    bus.i_S_BVALID = 1'b0;
    check("t6_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check("t6_rsp_count", rsp_cnt - cnt_snap, 32'd0);
    send(1'b0, 2'd2, 8'h00);
    exp_q.push_back('{wr: 1'b0, rdata: 8'hE1, resp: 2'b11});
    bus.i_S_ARREADY = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("t6_arvalid", {31'd0, bus.o_M_ARVALID}, 32'd1);
    tick();
    bus.i_S_ARREADY = 1'b0;
    bus.i_S_RVALID = 1'b1; bus.i_S_RDATA = 8'hE1; bus.i_S_RRESP = 2'b11;
    tick();
    bus.i_S_RVALID = 1'b0;
    check("t6_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    tick();
    check("t6_rsp_done", {31'd0, rsp_valid}, 32'd0);
    rsp_ready = 1'b0;

    tick();
    check("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/basic_axi4_lite_master.md
Name: basic_axi4_lite_master

Overview:
- Single-outstanding AXI4-Lite master that sits directly upstream of basic_axi4_lite_slave.
- Converts simple command requests (read or write, address, data) from user logic into AXI4-Lite AW/W/B or AR/R transactions.
- Returns one response per command: read data and response code.
- Used as the bus front-end for register-access test and control logic.

Parameters:
p_ADDRESS_WIDTH, 2, width of AXI address and command address
p_DATA_WIDTH, 8, width of AXI data and command/response data

Ports:
i_ACLK  in  1  clock; all logic on rising edge
i_ARESET  in  1  synchronous, active-high reset
i_CMD_VALID  in  1  command request valid
o_CMD_READY  out  1  command accepted when VALID&READY
i_CMD_WRITE  in  1  1=write, 0=read
i_CMD_ADDR  in  p_ADDRESS_WIDTH  command address
i_CMD_WDATA  in  p_DATA_WIDTH  write data (ignored for reads)
o_RSP_VALID  out  1  response valid
i_RSP_READY  in  1  response consumed when VALID&READY
o_RSP_WRITE  out  1  response belongs to a write
o_RSP_RDATA  out  p_DATA_WIDTH  captured RDATA (0 for writes)
o_RSP_RESP  out  2  captured BRESP/RRESP
o_M_AWADDR  out  p_ADDRESS_WIDTH  write address
o_M_AWVALID  out  1  write address valid
i_S_AWREADY  in  1  write address ready
o_M_WDATA  out  p_DATA_WIDTH  write data
o_M_WVALID  out  1  write data valid
i_S_WREADY  in  1  write data ready
i_S_BRESP  in  2  write response
i_S_BVALID  in  1  write response valid
o_M_BREADY  out  1  write response ready
o_M_ARADDR  out  p_ADDRESS_WIDTH  read address
o_M_ARVALID  out  1  read address valid
i_S_ARREADY  in  1  read address ready
i_S_RDATA  in  p_DATA_WIDTH  read data
i_S_RRESP  in  2  read response
i_S_RVALID  in  1  read data valid
o_M_RREADY  out  1  read data ready

Behaviour:
- Reset (i_ARESET=1 at a clock edge):
  - state=IDLE.
  - All o_M_*VALID, o_M_BREADY, o_M_RREADY and o_RSP_VALID = 0.
  - o_RSP_RDATA, o_RSP_RESP, o_RSP_WRITE, addresses and WDATA = 0.
  - Reset aborts any in-flight transaction; no response is produced for it.
- o_CMD_READY = (state==IDLE) & ~i_ARESET, combinational. It is the only combinational output.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - On CMD handshake, register address/data into o_M_AWADDR/o_M_WDATA or o_M_ARADDR.
  - Write: set AWVALID=WVALID=1, go to WR_ADDR_DATA.
  - Read: set ARVALID=1, go to RD_ADDR.
  - VALID rises the cycle after command acceptance (1-cycle latency).
- WR_ADDR_DATA:
  - AWVALID clears on the edge where AWVALID&AWREADY; WVALID clears independently on WVALID&WREADY.
  - Both may complete on the same edge or in either order.
  - When both are complete, set BREADY=1 and go to WR_RESP.
- WR_RESP: on BVALID&BREADY, capture BRESP into o_RSP_RESP, set RDATA=0, WRITE=1, BREADY=0, RSP_VALID=1, go to RSP.
- RD_ADDR: on ARVALID&ARREADY, clear ARVALID, set RREADY=1, go to RD_DATA.
- RD_DATA: on RVALID&RREADY, capture RDATA/RRESP, set WRITE=0, RREADY=0, RSP_VALID=1, go to RSP.
- RSP: response outputs held stable until RSP_VALID&RSP_READY, then RSP_VALID=0 and go to IDLE. The next command can be accepted the following cycle.
- AXI rules:
  - Once a VALID is asserted, its address/data stay stable and VALID stays high until handshake; no VALID depends on READY.
  - BVALID/RVALID are ignored outside WR_RESP/RD_DATA.
- Exactly one transaction outstanding; no pipelining of commands.
- Bus responses are passed through unmodified (00/01/10/11). No timeout.

Test Plan:
1. Reset held 3 cycles, then released, with i_CMD_VALID=1 during reset -> all VALIDs 0 during reset; o_CMD_READY=0 during reset and 1 in the first cycle after release.
2. Write addr=0, data=9; slave AWREADY=WREADY=1; BVALID returned next cycle with BRESP=00 -> AWVALID/WVALID high exactly 1 cycle, BREADY=1, then o_RSP_VALID=1, o_RSP_WRITE=1, o_RSP_RESP=00, o_RSP_RDATA=0.
3. Write addr=2, data=8'hA5, with WREADY delayed 3 cycles after AWREADY -> AWVALID drops after its handshake; WVALID and WDATA=A5 held stable 3 more cycles; exactly one response.
4. Read addr=0 following test 2; slave returns RDATA=9, RRESP=00 after 2-cycle RVALID delay -> ARVALID held until ARREADY, RREADY=1 until RVALID; o_RSP_RDATA=9, o_RSP_WRITE=0.
5. Read with RRESP=2'b10; hold i_RSP_READY=0 for 5 cycles with i_CMD_VALID=1 -> o_RSP_RESP=10 and outputs stable for 5 cycles; o_CMD_READY=0; second command accepted only the cycle after the RSP handshake.
6. Assert i_ARESET for one cycle while in WR_RESP -> next cycle BREADY=0 and all VALIDs 0; a later BVALID produces no response; next command completes normally.
